// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master between two requesters.
// Latches the winner's command, issues a start pulse and guards completion with a watchdog.
module i2c_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TW             = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [13:0] req_addr,
  input  logic [1:0]  req_rw,
  input  logic [15:0] req_wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [7:0]  rdata,
  output logic        nack,
  output logic        tmo,
  output logic        interupt,
  input  logic        irq_clr,
  output logic        m_start,
  output logic [6:0]  m_addr,
  output logic        m_rw,
  output logic [7:0]  m_wdata,
  input  logic        m_busy,
  input  logic        m_done,
  input  logic [7:0]  m_rdata,
  input  logic        m_nack
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        r_state;
  logic          r_ptr;
  logic          r_sel;
  logic [TW-1:0] r_wd;
  logic          w_pick;

  // Pointer's requester wins if it is asking, otherwise the other one gets the bus.
  always_comb begin
    w_pick = r_ptr;
    if (!req[r_ptr]) w_pick = ~r_ptr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= 1'b0;
      r_sel    <= 1'b0;
      r_wd     <= '0;
      gnt      <= 2'b00;
      done     <= 2'b00;
      rdata    <= 8'h00;
      nack     <= 1'b0;
      tmo      <= 1'b0;
      interupt <= 1'b0;
      m_start  <= 1'b0;
      m_addr   <= 7'h00;
      m_rw     <= 1'b0;
      m_wdata  <= 8'h00;
    end else begin
      done    <= 2'b00;
      m_start <= 1'b0;

      // An error being reported this cycle takes precedence over a clear request.
      if ((r_state == S_DONE) && (nack || tmo)) begin
        interupt <= 1'b1;
      end else if (irq_clr) begin
        interupt <= 1'b0;
      end

      unique case (r_state)
        S_IDLE: begin
          if (req != 2'b00) begin
            r_sel   <= w_pick;
            gnt     <= w_pick ? 2'b10 : 2'b01;
            m_addr  <= w_pick ? req_addr[13:7] : req_addr[6:0];
            m_rw    <= req_rw[w_pick];
            m_wdata <= w_pick ? req_wdata[15:8] : req_wdata[7:0];
            r_state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (!m_busy) begin
            m_start <= 1'b1;
            r_wd    <= '0;
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          // A completion landing on the last watchdog cycle still counts as success.
          if (m_done) begin
            if (m_rw) rdata <= m_rdata;
            nack    <= m_nack;
            tmo     <= 1'b0;
            done    <= r_sel ? 2'b10 : 2'b01;
            r_state <= S_DONE;
          end else if (r_wd == WD_LAST) begin
            tmo     <= 1'b1;
            nack    <= 1'b0;
            done    <= r_sel ? 2'b10 : 2'b01;
            r_state <= S_DONE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end

        S_DONE: begin
          gnt     <= 2'b00;
          r_ptr   <= ~r_sel;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed self-checking bench for i2c_bus_arbiter with a short watchdog.
// The bench itself plays the I2C master through m_busy/m_done/m_rdata/m_nack.
module tb_i2c_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [13:0] req_addr;
  logic [1:0]  req_rw;
  logic [15:0] req_wdata;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [7:0]  rdata;
  logic        nack;
  logic        tmo;
  logic        interupt;
  logic        irq_clr;
  logic        m_start;
  logic [6:0]  m_addr;
  logic        m_rw;
  logic [7:0]  m_wdata;
  logic        m_busy;
  logic        m_done;
  logic [7:0]  m_rdata;
  logic        m_nack;

  int assertCount = 0;
  int failCount   = 0;
  int monBad      = 0;
  logic startSeen;

  i2c_bus_arbiter #(.TIMEOUT_CYCLES(16), .TW(5)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .nack(nack),
    .tmo(tmo), .interupt(interupt), .irq_clr(irq_clr), .m_start(m_start),
    .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata), .m_busy(m_busy),
    .m_done(m_done), .m_rdata(m_rdata), .m_nack(m_nack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Grants and done pulses must stay one-hot, and done only to the granted side.
  always @(negedge clk) begin
    if (reset && (($countones(gnt) > 1) || ($countones(done) > 1) || ((done & ~gnt) != 2'b00)))
      monBad++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] rw,
                               input logic [6:0] a0, input logic [6:0] a1,
                               input logic [7:0] w0, input logic [7:0] w1);
    req       = r;
    req_rw    = rw;
    req_addr  = {a1, a0};
    req_wdata = {w1, w0};
  endtask

  initial begin
    reset   = 1'b0;
    irq_clr = 1'b0;
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_rdata = 8'h00;
    m_nack  = 1'b0;
    applyStimulus(2'b00, 2'b00, 7'h00, 7'h00, 8'h00, 8'h00);
    tick(2);
    checkOutput("rst_gnt", 16'(gnt), 16'h0);
    checkOutput("rst_done", 16'(done), 16'h0);
    checkOutput("rst_start", 16'(m_start), 16'h0);
    checkOutput("rst_misc", {rdata, nack, tmo, interupt, 5'b0}, 16'h0);
    checkOutput("rst_maddr", {m_addr, m_rw, m_wdata}, 16'h0);
    reset = 1'b1;
    tick(1);

    $display("[TB] single write from requester 0");
    applyStimulus(2'b01, 2'b00, 7'h50, 7'h00, 8'hA5, 8'h00);
    tick(1);
    checkOutput("t1_gnt", 16'(gnt), 16'h1);
    checkOutput("t1_maddr", 16'(m_addr), 16'h50);
    checkOutput("t1_mwdata", 16'(m_wdata), 16'hA5);
    checkOutput("t1_start_early", 16'(m_start), 16'h0);
    tick(1);
    checkOutput("t1_start", 16'(m_start), 16'h1);
    tick(1);
    checkOutput("t1_start_single", 16'(m_start), 16'h0);
    tick(8);
    checkOutput("t1_no_early_done", 16'(done), 16'h0);
    m_done = 1'b1;
    m_nack = 1'b0;
    tick(1);
    checkOutput("t1_done", 16'(done), 16'h1);
    checkOutput("t1_gnt_at_done", 16'(gnt), 16'h1);
    checkOutput("t1_nack_tmo", {nack, tmo}, 16'h0);
    m_done = 1'b0;
    req    = 2'b00;
    tick(1);
    checkOutput("t1_done_once", 16'(done), 16'h0);
    checkOutput("t1_gnt_drop", 16'(gnt), 16'h0);
    checkOutput("t1_irq", 16'(interupt), 16'h0);
    tick(1);

    $display("[TB] simultaneous requests from reset");
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    applyStimulus(2'b11, 2'b00, 7'h11, 7'h22, 8'h01, 8'h02);
    tick(1);
    checkOutput("t2_gnt0", 16'(gnt), 16'h1);
    checkOutput("t2_maddr0", 16'(m_addr), 16'h11);
    tick(1);
    checkOutput("t2_start0", 16'(m_start), 16'h1);
    tick(4);
    m_done = 1'b1;
    tick(1);
    checkOutput("t2_done0", 16'(done), 16'h1);
    m_done = 1'b0;
    tick(1);
    checkOutput("t2_gap", 16'(gnt), 16'h0);
    tick(1);
    checkOutput("t2_gnt1", 16'(gnt), 16'h2);
    checkOutput("t2_maddr1", 16'(m_addr), 16'h22);
    checkOutput("t2_mwdata1", 16'(m_wdata), 16'h02);
    req = 2'b10;
    tick(1);
    checkOutput("t2_start1", 16'(m_start), 16'h1);
    tick(4);
    m_done = 1'b1;
    tick(1);
    checkOutput("t2_done1", 16'(done), 16'h2);
    m_done = 1'b0;
    req    = 2'b00;
    tick(2);

    $display("[TB] requester 1 read with slave nack");
    applyStimulus(2'b10, 2'b10, 7'h00, 7'h3B, 8'h00, 8'h77);
    tick(1);
    checkOutput("t3_gnt", 16'(gnt), 16'h2);
    checkOutput("t3_mrw", 16'(m_rw), 16'h1);
    tick(1);
    checkOutput("t3_start", 16'(m_start), 16'h1);
    tick(3);
    m_done  = 1'b1;
    m_rdata = 8'h3C;
    m_nack  = 1'b1;
    tick(1);
    checkOutput("t3_done", 16'(done), 16'h2);
    checkOutput("t3_rdata", 16'(rdata), 16'h3C);
    checkOutput("t3_nack_tmo", {nack, tmo}, 16'h2);
    m_done = 1'b0;
    m_nack = 1'b0;
    req    = 2'b00;
    tick(1);
    checkOutput("t3_irq_set", 16'(interupt), 16'h1);
    tick(3);
    checkOutput("t3_irq_sticky", 16'(interupt), 16'h1);
    irq_clr = 1'b1;
    tick(1);
    checkOutput("t3_irq_clr", 16'(interupt), 16'h0);
    irq_clr = 1'b0;

    $display("[TB] watchdog timeout, then completion on the last cycle");
    applyStimulus(2'b01, 2'b00, 7'h44, 7'h00, 8'h10, 8'h00);
    tick(2);
    checkOutput("t4_start", 16'(m_start), 16'h1);
    tick(15);
    checkOutput("t4_no_early_done", 16'(done), 16'h0);
    tick(1);
    checkOutput("t4_done", 16'(done), 16'h1);
    checkOutput("t4_nack_tmo", {nack, tmo}, 16'h1);
    irq_clr = 1'b1;
    req     = 2'b00;
    tick(1);
    checkOutput("t4_set_beats_clr", 16'(interupt), 16'h1);
    tick(1);
    checkOutput("t4_irq_clr", 16'(interupt), 16'h0);
    irq_clr = 1'b0;
    req     = 2'b01;
    tick(2);
    checkOutput("t4b_start", 16'(m_start), 16'h1);
    tick(15);
    m_done = 1'b1;
    m_nack = 1'b0;
    tick(1);
    checkOutput("t4b_done", 16'(done), 16'h1);
    checkOutput("t4b_mdone_wins", {nack, tmo}, 16'h0);
    m_done = 1'b0;
    req    = 2'b00;
    tick(1);
    checkOutput("t4b_no_irq", 16'(interupt), 16'h0);
    tick(1);

    $display("[TB] busy master delays start");
    m_busy  = 1'b1;
    m_rdata = 8'hFF;
    applyStimulus(2'b10, 2'b00, 7'h00, 7'h2A, 8'h00, 8'h5A);
    tick(1);
    checkOutput("t5_gnt", 16'(gnt), 16'h2);
    startSeen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      startSeen = startSeen | m_start;
    end
    checkOutput("t5_no_start_busy", 16'(startSeen), 16'h0);
    m_busy = 1'b0;
    tick(1);
    checkOutput("t5_start", 16'(m_start), 16'h1);
    tick(1);
    checkOutput("t5_start_single", 16'(m_start), 16'h0);
    m_done = 1'b1;
    m_nack = 1'b1;
    tick(1);
    checkOutput("t5_done", 16'(done), 16'h2);
    checkOutput("t5_rdata_hold", 16'(rdata), 16'h3C);
    m_done = 1'b0;
    m_nack = 1'b0;
    req    = 2'b00;
    tick(1);
    checkOutput("t5_irq", 16'(interupt), 16'h1);
    tick(1);

    $display("[TB] reset during WAIT");
    applyStimulus(2'b01, 2'b01, 7'h50, 7'h00, 8'h00, 8'h00);
    tick(2);
    tick(3);
    reset = 1'b0;
    #1;
    checkOutput("t6_gnt", 16'(gnt), 16'h0);
    checkOutput("t6_done_start", {done, m_start}, 16'h0);
    checkOutput("t6_irq", 16'(interupt), 16'h0);
    checkOutput("t6_rdata", 16'(rdata), 16'h0);
    req = 2'b00;
    tick(1);
    reset = 1'b1;
    tick(1);
    applyStimulus(2'b01, 2'b01, 7'h48, 7'h00, 8'h00, 8'h00);
    tick(1);
    checkOutput("t6_regnt", 16'(gnt), 16'h1);
    checkOutput("t6_maddr", 16'(m_addr), 16'h48);
    tick(1);
    checkOutput("t6_start", 16'(m_start), 16'h1);
    tick(2);
    m_done  = 1'b1;
    m_rdata = 8'h96;
    tick(1);
    checkOutput("t6_done", 16'(done), 16'h1);
    checkOutput("t6_rdata_new", 16'(rdata), 16'h96);
    m_done = 1'b0;
    req    = 2'b00;
    tick(2);

    checkOutput("onehot_monitor", 16'(monBad), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
